// File: rtl/pacman_pkg.sv
// Shared PacMan board constants, block codes and sequencer state encoding.
// Imported by board_update_sequencer and sprite_slot.
package pacman_pkg;

  localparam int BOARD_W  = 32;
  localparam int BOARD_H  = 24;
  localparam int BLOCK_PX = 20;

  localparam logic [3:0] EMPTY_TILE = 4'd0;
  localparam logic [3:0] WALL       = 4'd1;
  localparam logic [3:0] PELLET     = 4'd2;
  localparam logic [3:0] PAC        = 4'd3;
  localparam logic [3:0] BLINKY     = 4'd4;
  localparam logic [3:0] PINKY      = 4'd5;
  localparam logic [3:0] INKY       = 4'd6;
  localparam logic [3:0] CLYDE      = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ERASE,
    S_READ,
    S_CAPTURE,
    S_DRAW,
    S_ADVANCE,
    S_FINISH
  } seq_state_t;

endpackage

// File: rtl/board_update_sequencer_sprite_slot.sv
// Per-channel sprite record: current location, valid bit, saved underlay.
// Ports: clk, reset_n, loc_ld/loc_in, und_ld/und_in -> cur_loc, valid, underlay.
module sprite_slot
  import pacman_pkg::*;
#(
  parameter int                ADDR_W = 10,
  parameter int                TYPE_W = 4,
  parameter logic [TYPE_W-1:0] EMPTY  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              loc_ld,
  input  logic [ADDR_W-1:0] loc_in,
  input  logic              und_ld,
  input  logic [TYPE_W-1:0] und_in,
  output logic [ADDR_W-1:0] cur_loc,
  output logic              valid,
  output logic [TYPE_W-1:0] underlay
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_loc  <= '0;
      valid    <= 1'b0;
      underlay <= EMPTY;
    end else begin
      if (loc_ld) begin
        cur_loc <= loc_in;
        valid   <= 1'b1;
      end
      if (und_ld) underlay <= und_in;
    end
  end

endmodule

// File: rtl/board_update_sequencer.sv
// Per-tick board RAM updater for NUM_SPRITES sprites sharing one RAM port.
// Ports: clk, reset_n, tick, sprite_next/code, mem_* req/gnt port,
// busy, done, collision. Option: PACMAN_COLLISION_EN builds the detector.
module board_update_sequencer
  import pacman_pkg::*;
#(
  parameter int                NUM_SPRITES = 5,
  parameter int                ADDR_W      = 10,
  parameter int                TYPE_W      = 4,
  parameter logic [TYPE_W-1:0] EMPTY_TILE  = 4'd0,
  parameter logic [TYPE_W-1:0] SPRITE_MIN  = 4'd3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          tick,
  input  logic [NUM_SPRITES*ADDR_W-1:0] sprite_next,
  input  logic [NUM_SPRITES*TYPE_W-1:0] sprite_code,
  output logic                          mem_req,
  input  logic                          mem_gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_wren,
  output logic [TYPE_W-1:0]             mem_wdata,
  input  logic [TYPE_W-1:0]             mem_q,
  output logic                          busy,
  output logic                          done,
  output logic                          collision
);

  localparam int CH_W =
    (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_SPRITES - 1);

  seq_state_t state;
  seq_state_t state_nx;

  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] nxt_sh   [NUM_SPRITES];
  logic [TYPE_W-1:0] code_sh  [NUM_SPRITES];
  logic [ADDR_W-1:0] cur_loc  [NUM_SPRITES];
  logic [TYPE_W-1:0] underlay [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] valid;

  logic              loc_ld;
  logic              und_ld;
  logic [TYPE_W-1:0] und_in;
  logic              accept;

  logic [ADDR_W-1:0] sel_next;
  logic [ADDR_W-1:0] sel_cur;
  logic [TYPE_W-1:0] sel_code;
  logic [TYPE_W-1:0] sel_und;
  logic              sel_valid;

  assign accept    = (state == S_IDLE) && tick;
  assign sel_next  = nxt_sh[ch];
  assign sel_cur   = cur_loc[ch];
  assign sel_code  = code_sh[ch];
  assign sel_und   = underlay[ch];
  assign sel_valid = valid[ch];

  // Sprite codes seen under a new location are never restored later.
  assign und_in = (mem_q >= SPRITE_MIN) ? EMPTY_TILE : mem_q;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
    sprite_slot #(
      .ADDR_W(ADDR_W),
      .TYPE_W(TYPE_W),
      .EMPTY (EMPTY_TILE)
    ) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .loc_ld  (loc_ld && (ch == CH_W'(i))),
      .loc_in  (nxt_sh[i]),
      .und_ld  (und_ld && (ch == CH_W'(i))),
      .und_in  (und_in),
      .cur_loc (cur_loc[i]),
      .valid   (valid[i]),
      .underlay(underlay[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ch    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        nxt_sh[i]  <= '0;
        code_sh[i] <= '0;
      end
    end else begin
      state <= state_nx;
      done  <= (state == S_FINISH);
      if (accept) begin
        busy <= 1'b1;
        ch   <= '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
          nxt_sh[i]  <= sprite_next[i*ADDR_W +: ADDR_W];
          code_sh[i] <= sprite_code[i*TYPE_W +: TYPE_W];
        end
      end
      if (state == S_ADVANCE && ch != LAST)
        ch <= ch + 1'b1;
      if (state == S_FINISH)
        busy <= 1'b0;
    end
  end

  // wren is a pure function of state and gnt, so it drops with reset.
  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wren  = 1'b0;
    mem_wdata = '0;
    loc_ld    = 1'b0;
    und_ld    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (sel_valid && sel_next == sel_cur)
          state_nx = S_ADVANCE;
        else if (sel_valid)
          state_nx = S_ERASE;
        else
          state_nx = S_READ;
      end
      S_ERASE: begin
        mem_req   = 1'b1;
        mem_addr  = sel_cur;
        mem_wdata = (ch == '0) ? EMPTY_TILE : sel_und;
        mem_wren  = mem_gnt;
        if (mem_gnt) state_nx = S_READ;
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = sel_next;
        if (mem_gnt) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        und_ld   = 1'b1;
        state_nx = S_DRAW;
      end
      S_DRAW: begin
        mem_req   = 1'b1;
        mem_addr  = sel_next;
        mem_wdata = sel_code;
        mem_wren  = mem_gnt;
        if (mem_gnt) begin
          loc_ld   = 1'b1;
          state_nx = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        state_nx = (ch == LAST) ? S_FINISH : S_CHECK;
      end
      S_FINISH: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef PACMAN_COLLISION_EN
  logic hit;
  logic coll_q;

  always_comb begin
    hit = 1'b0;
    for (int i = 1; i < NUM_SPRITES; i++)
      if (valid[i] && valid[0] && cur_loc[i] == cur_loc[0])
        hit = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      coll_q <= 1'b0;
    else if (state == S_FINISH)
      coll_q <= hit;
  end

  assign collision = coll_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: doc/board_update_sequencer.md
Name: board_update_sequencer

Overview:
- Replaces the single-sprite, compare-against-scan-address write logic with a parametrised sequencer that updates the tile board RAM for NUM_SPRITES sprites (channel 0 = PacMan, 1..N-1 = ghosts) once per game tick.
- For each channel that moved, it restores the tile under the old location, samples the tile at the new location, and draws the sprite.
- It shares the single board RAM port with the video tile fetcher through a req/gnt handshake.
- It reports a frame-done pulse and ghost/PacMan collision.

Parameters:
- NUM_SPRITES, 5, number of sprite channels; channel 0 is PacMan.
- ADDR_W, 10, board RAM address width (32x24 = 768 blocks).
- TYPE_W, 4, block-type code width.
- EMPTY_TILE, 4'd0, code written where PacMan has been.
- SPRITE_MIN, 4'd3, block codes >= SPRITE_MIN are sprite codes and are never saved as underlay.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle pulse that starts an update pass; ignored while busy.
- sprite_next  in  NUM_SPRITES*ADDR_W  packed next block address per channel; sampled on the accepted tick.
- sprite_code  in  NUM_SPRITES*TYPE_W  packed block code to draw per channel.
- mem_req  out  1  request for the board RAM port.
- mem_gnt  in  1  port granted this cycle.
- mem_addr  out  ADDR_W  RAM address; valid when mem_req is high.
- mem_wren  out  1  write enable; only ever high when mem_gnt is high.
- mem_wdata  out  TYPE_W  write data.
- mem_q  in  TYPE_W  RAM read data, 1-cycle latency after the address.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when a pass completes.
- collision  out  1  registered flag; some ghost location equals the PacMan location after the pass.

Behaviour:
- Reset (asynchronous, active-low) clears:
  - all outputs to 0;
  - state to IDLE;
  - channel index to 0;
  - all cur_loc registers;
  - all valid bits;
  - all underlay registers to EMPTY_TILE.
- A tick in IDLE latches sprite_next and sprite_code into shadow registers, sets busy, sets ch=0 and goes to CHECK.
- CHECK (1 cycle):
  - if valid[ch] is set and next==cur, go to ADVANCE;
  - else if valid[ch] is set, go to ERASE;
  - else go to READ.
- ERASE: assert mem_req, mem_addr=cur_loc[ch], mem_wdata = EMPTY_TILE for ch 0 or underlay[ch] otherwise. mem_wren goes high only in a cycle with mem_gnt; hold until granted, then go to READ.
- READ: mem_req, mem_addr=next[ch], wren=0. Hold until granted, then go to CAPTURE.
- CAPTURE: on the following cycle, underlay[ch] = (mem_q >= SPRITE_MIN) ? EMPTY_TILE : mem_q. Go to DRAW.
  - Channel 0's underlay is unused.
  - The underlay register exists for every channel for uniformity.
- DRAW: mem_req, mem_addr=next[ch], wdata=code[ch]. Write on grant, then set cur_loc[ch]=next[ch] and valid[ch]=1, and go to ADVANCE.
- ADVANCE:
  - if ch==NUM_SPRITES-1, go to FINISH;
  - else increment ch and go to CHECK.
- FINISH: update collision, pulse done for 1 cycle, clear busy, go to IDLE.
- mem_req drops whenever the state is not ERASE/READ/DRAW.
- A grant that arrives in READ is consumed by the read; mem_q must not be sampled unless the previous cycle was a granted READ.
- Latency with mem_gnt tied to 1:
  - moved channel = 5 cycles (CHECK, ERASE, READ, CAPTURE, DRAW), plus 1 ADVANCE;
  - first-placement channel = 4 cycles + 1;
  - unchanged channel = 2 cycles.
- Channels are processed in index order. A later channel's erase may overwrite an earlier channel's draw when both share a block; this is accepted behaviour.
- A tick while busy is dropped. A tick coinciding with FINISH is dropped.
- Reset asserted mid-pass aborts immediately. mem_wren must fall asynchronously with reset_n.

Optional Feature:
- Macro: PACMAN_COLLISION_EN.
- Defined:
  - collision = OR over ghost channels of (valid[i] and cur_loc[i]==cur_loc[0] and valid[0]), registered in FINISH;
  - it holds until the next FINISH or reset.
- Undefined: collision is tied to 0 and no comparators are built.

Decomposition:
- Shared package pacman_pkg holds:
  - BOARD_W=32, BOARD_H=24, BLOCK_PX=20 constants;
  - block-code constants (EMPTY_TILE, WALL, PELLET, PAC, BLINKY, PINKY, INKY, CLYDE);
  - the seq_state_t enum.
- One natural sub-module: sprite_slot (per-channel cur_loc/valid/underlay registers with load strobes), instantiated NUM_SPRITES times via generate.

Test Plan:
- After reset, gnt=1, tick with next={300,100,101,102,103}, and RAM preloaded with 2 (pellet) everywhere → no erase writes; five read/draw pairs, with DRAW writes of code[i] at 300,100..103; done 26 cycles after tick; collision=0.
- Second tick with PacMan next=301 and ghost locations unchanged → write EMPTY_TILE@300 and code[0]@301; ghosts take 2 cycles each; done pulses once.
- Ghost 1 moves 100→132 where RAM[132]=2 → write 2@100, read 132, write code[1]@132; underlay[1]=2. Next move 132→133 → write 2@132.
- Toggle gnt 0/1 every other cycle during a pass → mem_wren never high with gnt=0; final RAM contents identical to the gnt=1 run.
- With PACMAN_COLLISION_EN defined, PacMan next=133 while ghost 1 is at 133 → collision=1 after done. Without the macro → collision stays 0.
- Assert reset_n low during DRAW → mem_wren and busy go 0 asynchronously; the following tick is treated as first placement (no erase writes).
